data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data word width; only 32 is supported.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of storage words; must be a power of two.
REQ-003 Parameter WAIT_CYCLES, default 1: extra wait states inserted between request acceptance and response; legal range 0..15.
REQ-004 i_clk  in  1  sole clock; all logic is on the rising edge.
REQ-005 i_reset_n  in  1  reset; synchronous, active-low.
REQ-006 i_req_valid  in  1  the CPU presents a load or store request.
REQ-007 o_req_ready  out  1  the responder can accept a request.
REQ-008 i_req_we  in  1  1 = store, 0 = load.
REQ-009 i_req_addr  in  32  byte address.
REQ-010 i_req_wdata  in  32  store data.
REQ-011 i_req_be  in  4  store byte enables; bit i selects byte lane [8i+7:8i].
REQ-012 o_rsp_valid  out  1  a response is present.
REQ-013 i_rsp_ready  in  1  the CPU accepts the response.
REQ-014 o_rsp_rdata  out  32  load data; 0 for stores and errored requests.
REQ-015 o_rsp_err  out  1  the request was rejected (misaligned or out of range).

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP; o_req_ready = 1 only in IDLE, and o_rsp_valid = 1 only in RESP.
REQ-017 On an IDLE cycle with i_req_valid=1, the block SHALL capture we/addr/wdata/be, then go to RESP if WAIT_CYCLES=0, else go to WAIT with its counter loaded with WAIT_CYCLES.
REQ-018 In WAIT, the counter SHALL decrement each cycle; the state changes to RESP on the cycle the counter equals 1.
REQ-019 Latency: a request accepted at edge N SHALL produce o_rsp_valid=1 after edge N+1+WAIT_CYCLES.
REQ-020 A store SHALL commit to storage on the edge entering RESP; only lanes with be[i]=1 are written, and be=0000 writes nothing but still responds.
REQ-021 A load SHALL register the full word into o_rsp_rdata on the edge entering RESP; be is ignored for loads.
REQ-022 The word index SHALL be addr[2 +: log2(DEPTH_WORDS)].
REQ-023 In RESP, o_rsp_rdata and o_rsp_err SHALL hold stable until i_rsp_ready=1, and the FSM returns to IDLE on that edge.
REQ-024 Requests SHALL NOT be pipelined: i_req_valid outside IDLE is ignored and not captured.
REQ-025 i_rsp_ready=1 while o_rsp_valid=0 SHALL have no effect.
REQ-026 A load issued immediately after a store to the same word SHALL return the stored data.

Reset
REQ-027 When i_reset_n=0 at an edge, the block SHALL set state=IDLE, counter=0, o_rsp_valid=0, o_rsp_rdata=0 and o_rsp_err=0; o_req_ready=1 after reset.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 Reset asserted in WAIT SHALL abandon the pending store with no write; reset in RESP SHALL drop the response.

Configuration
REQ-030 Macro DMEM_ERR_CHECK_EN defined: a request with addr[1:0]!=0 or addr >= 4*DEPTH_WORDS SHALL set o_rsp_err=1 and o_rsp_rdata=0, perform no write, and keep the same latency.
REQ-031 Macro undefined: o_rsp_err SHALL be tied to 0, addr[1:0] is ignored, and upper address bits wrap modulo DEPTH_WORDS.

Structure
REQ-032 Shared package dmem_pkg SHALL hold the FSM state enum (IDLE/WAIT/RESP), the byte-lane count constant (4) and the WAIT_CYCLES counter width (4).
REQ-033 Storage SHALL be a sub-module dmem_ram_array: single port, synchronous write with byte enables, registered read; the FSM stays in data_mem_responder.

Verification
REQ-034 WAIT_CYCLES=1: store addr=0x10, wdata=0xDEADBEEF, be=1111, then load 0x10 -> o_rsp_valid 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-035 Partial write: prior word 0xDEADBEEF, store be=0010 wdata=0x0000AA00 to 0x10, then load -> rdata=0xDEADAAEF.
REQ-036 Backpressure: hold i_rsp_ready=0 for 5 cycles in RESP with i_req_valid=1 -> o_rsp_valid stays 1, rdata stable, o_req_ready=0, no new capture; ready=1 -> IDLE next edge.
REQ-037 DMEM_ERR_CHECK_EN defined: load 0x12 -> err=1, rdata=0; store 0x1000 with DEPTH_WORDS=1024 -> err=1, then load 0x0 unchanged.
REQ-038 Reset mid-WAIT (WAIT_CYCLES=3): store 0x20=0x12345678, reset at 2nd WAIT cycle -> outputs zero, later load 0x20 returns the old value.
REQ-039 WAIT_CYCLES=0: back-to-back store/load to 0x40 with i_rsp_ready=1 -> response 1 cycle after each accept, load returns the stored word.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder.
// Holds the responder FSM state encoding, the number of byte lanes per word
// and the width of the wait-state counter.
package dmem_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_ram_array.sv
// Single-port word storage with byte-lane write enables and a registered read.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - synchronous active-low reset, clears only the read register
//   wr_en    - write the enabled lanes of wdata into word idx
//   rd_en    - load word idx into the read register
//   rd_clr   - load zero into the read register
//   idx      - word index
//   be       - byte-lane enables for writes
//   wdata    - write data
//   rdata    - registered read data
module dmem_ram_array
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [IDX_W-1:0]      idx,
    input  logic [LANES-1:0]      be,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned LANE_W = DATA_WIDTH / LANES;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (be[i]) begin
                    mem[idx][LANE_W*i +: LANE_W] <= wdata[LANE_W*i +: LANE_W];
                end
            end
        end
    end

    // Read register doubles as the response data register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end else if (rd_clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time from a CPU,
// inserts WAIT_CYCLES wait states, then presents a response held until the
// CPU accepts it.
// Ports:
//   i_clk, i_reset_n          - clock and synchronous active-low reset
//   i_req_valid/o_req_ready   - request handshake (ready only when idle)
//   i_req_we, i_req_addr      - store flag and byte address
//   i_req_wdata, i_req_be     - store data and byte enables
//   o_rsp_valid/i_rsp_ready   - response handshake
//   o_rsp_rdata, o_rsp_err    - load data (0 for stores/errors), error flag
// Build option DMEM_ERR_CHECK_EN: reject misaligned or out-of-range requests
// with o_rsp_err=1; when undefined, addr[1:0] is ignored and the upper
// address bits wrap.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [31:0]           i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [LANES-1:0]      i_req_be,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  cap_we;
    logic                  cap_err;
    logic [IDX_W-1:0]      cap_idx;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [LANES-1:0]      cap_be;

    logic                  req_err_c;
    logic                  enter_resp_c;
    logic                  sel_we_c;
    logic                  sel_err_c;
    logic [IDX_W-1:0]      sel_idx_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;
    logic [LANES-1:0]      sel_be_c;

`ifdef DMEM_ERR_CHECK_EN
    assign req_err_c = (i_req_addr[1:0] != 2'b00) ||
                       (i_req_addr[31:IDX_W+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_req_addr[1:0], i_req_addr[31:IDX_W+2]};
    assign req_err_c        = 1'b0;
`endif

    // With zero wait states the request commits on its accept edge, so the
    // storage sees the live inputs in IDLE and the captured copy otherwise.
    assign sel_we_c    = (state == IDLE) ? i_req_we                  : cap_we;
    assign sel_err_c   = (state == IDLE) ? req_err_c                 : cap_err;
    assign sel_idx_c   = (state == IDLE) ? i_req_addr[2 +: IDX_W]    : cap_idx;
    assign sel_wdata_c = (state == IDLE) ? i_req_wdata               : cap_wdata;
    assign sel_be_c    = (state == IDLE) ? i_req_be                  : cap_be;

    assign enter_resp_c = ((state == IDLE) && i_req_valid && (WAIT_CYCLES == 0)) ||
                          ((state == WAIT) && (cnt == CNT_W'(1)));

    // Request FSM with registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            cap_we      <= 1'b0;
            cap_err     <= 1'b0;
            cap_idx     <= '0;
            cap_wdata   <= '0;
            cap_be      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        cap_we      <= i_req_we;
                        cap_err     <= req_err_c;
                        cap_idx     <= i_req_addr[2 +: IDX_W];
                        cap_wdata   <= i_req_wdata;
                        cap_be      <= i_req_be;
                        o_req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_err   <= req_err_c;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= cap_err;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                        o_rsp_err   <= 1'b0;
                        o_req_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_req_ready <= 1'b1;
                    o_rsp_valid <= 1'b0;
                    o_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    // Writes are gated by reset so a store abandoned by reset never lands.
    dmem_ram_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .wr_en   (enter_resp_c && sel_we_c && !sel_err_c && i_reset_n),
        .rd_en   (enter_resp_c && !sel_we_c && !sel_err_c),
        .rd_clr  (enter_resp_c && (sel_we_c || sel_err_c)),
        .idx     (sel_idx_c),
        .be      (sel_be_c),
        .wdata   (sel_wdata_c),
        .rdata   (o_rsp_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances with 0, 1 and 3
// wait states, randomized loads/stores against a word-array reference model.
module tb_data_mem_responder;

`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .DATA_WIDTH  (32),
            .DEPTH_WORDS (1024),
            .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .i_clk       (clk),
            .i_reset_n   (rst_n[g]),
            .i_req_valid (req_valid[g]),
            .o_req_ready (req_ready[g]),
            .i_req_we    (req_we[g]),
            .i_req_addr  (req_addr[g]),
            .i_req_wdata (req_wdata[g]),
            .i_req_be    (req_be[g]),
            .o_rsp_valid (rsp_valid[g]),
            .i_rsp_ready (rsp_ready[g]),
            .o_rsp_rdata (rsp_rdata[g]),
            .o_rsp_err   (rsp_err[g])
        );
    end

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [3][1024];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          bp_req = 0;
    int          hold [3] = '{0, 0, 0};
    bit          busy [3] = '{0, 0, 0};
    logic [31:0] held_rd [3];
    logic        held_er [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at cycle %0d", name, d, act, exp, cyc);
        end
    endtask

    // Reference: memory is an array of words; errors touch nothing.
    function automatic void model(input int d, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  output logic [31:0] rdata, output logic err);
        int idx;
        err   = ERR_EN && (((addr % 4) != 0) || (addr >= 32'd4096));
        idx   = int'((addr / 4) % 1024);
        rdata = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mdl[d][idx][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                rdata = mdl[d][idx];
            end
        end
    endfunction

    // Called on a negedge; returns one negedge after the request handshake.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int extra_valid, input bit push);
        logic [31:0] r;
        logic        e;
        int          t = 0;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        while (!req_ready[d] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL req_timeout dut%0d: ready stayed 0, required 1", d);
        end else if (push) begin
            model(d, we, addr, wdata, be, r, e);
            q.push_back('{d: d, rdata: r, err: e, due: cyc + wc(d) + 1});
        end
        repeat (extra_valid + 1) @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || busy[0] || busy[1] || busy[2]) && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 31)) << 2;
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(0, 3));
        return a;
    endfunction

    // Monitor: pops the scoreboard on each new response, checks stability
    // while the response is held, and drives rsp_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rst_n[d] && rsp_valid[d]) begin
                    check("req_ready_in_resp", d, 32'(req_ready[d]), 32'h0);
                    if (!busy[d]) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_rsp dut%0d: got rdata %h with empty scoreboard", d, rsp_rdata[d]);
                        end else begin
                            e = q.pop_front();
                            check("rsp_dut", d, 32'(d), 32'(e.d));
                            check("rsp_rdata", d, rsp_rdata[d], e.rdata);
                            check("rsp_err", d, 32'(rsp_err[d]), 32'(e.err));
                            check("rsp_latency", d, 32'(cyc), 32'(e.due));
                        end
                        busy[d]    = 1'b1;
                        held_rd[d] = rsp_rdata[d];
                        held_er[d] = rsp_err[d];
                        if (bp_req > 0) begin
                            hold[d] = bp_req;
                            bp_req  = 0;
                        end
                    end else begin
                        check("rdata_stable", d, rsp_rdata[d], held_rd[d]);
                        check("err_stable", d, 32'(rsp_err[d]), 32'(held_er[d]));
                    end
                    if (hold[d] > 1) begin
                        rsp_ready[d] = 1'b0;
                        hold[d]--;
                    end else if (hold[d] == 1) begin
                        rsp_ready[d] = 1'b1;
                        hold[d] = 0;
                    end else begin
                        rsp_ready[d] = ($urandom_range(0, 2) != 0);
                    end
                    if (rsp_ready[d]) busy[d] = 1'b0;
                end else begin
                    rsp_ready[d] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
            req_be[d]    = 4'h0;
            rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_rsp_valid", d, 32'(rsp_valid[d]), 32'h0);
            check("reset_rsp_rdata", d, rsp_rdata[d], 32'h0);
            check("reset_rsp_err", d, 32'(rsp_err[d]), 32'h0);
            check("reset_req_ready", d, 32'(req_ready[d]), 32'h1);
            rst_n[d] = 1'b1;
        end
        @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            // Fill the working region so every load has a defined value.
            for (int w = 0; w < 32; w++) issue(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b1);

            if (d == 1) begin
                issue(d, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 1'b1);
                issue(d, 1'b0, 32'h10, $urandom, 4'b0000, 0, 1'b1);
                issue(d, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, 0, 1'b1);
                issue(d, 1'b0, 32'h10, $urandom, 4'b1111, 0, 1'b1);
                issue(d, 1'b1, 32'h14, 32'h5555_5555, 4'b0000, 0, 1'b1);
                issue(d, 1'b0, 32'h14, 32'h0, 4'b0000, 0, 1'b1);
                drain();
                bp_req = 6;
                issue(d, 1'b0, 32'h10, 32'h0, 4'b0000, wc(d) + 5, 1'b1);
                drain();
                issue(d, 1'b0, 32'h12, 32'h0, 4'b0000, 0, 1'b1);
                issue(d, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'b1111, 0, 1'b1);
                issue(d, 1'b0, 32'h0, 32'h0, 4'b0000, 0, 1'b1);
            end

            if (d == 0) begin
                issue(d, 1'b1, 32'h40, 32'hA5A5_1234, 4'b1111, 0, 1'b1);
                issue(d, 1'b0, 32'h40, 32'h0, 4'b0000, 0, 1'b1);
            end

            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(d, 1'($urandom), rand_addr(), $urandom, 4'($urandom), 0, 1'b1);
            end
            drain();

            if (d == 2) begin
                issue(d, 1'b1, 32'h20, 32'h0BAD_F00D, 4'b1111, 0, 1'b1);
                issue(d, 1'b0, 32'h20, 32'h0, 4'b0000, 0, 1'b1);
                drain();
                // Store abandoned by reset during its second wait cycle.
                issue(d, 1'b1, 32'h20, 32'h1234_5678, 4'b1111, 0, 1'b0);
                @(negedge clk);
                rst_n[d] = 1'b0;
                @(negedge clk);
                check("midwait_rsp_valid", d, 32'(rsp_valid[d]), 32'h0);
                check("midwait_rsp_rdata", d, rsp_rdata[d], 32'h0);
                check("midwait_rsp_err", d, 32'(rsp_err[d]), 32'h0);
                check("midwait_req_ready", d, 32'(req_ready[d]), 32'h1);
                rst_n[d] = 1'b1;
                @(negedge clk);
                issue(d, 1'b0, 32'h20, 32'h0, 4'b0000, 0, 1'b1);
                drain();
            end
        end

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
